// File: rtl/serial_adder.sv
// serial_adder -- bit-serial WIDTH-bit adder.
//
// One full-adder slice (two NAND-built half adders plus a carry OR) and a
// carry flop add the operands LSB-first, one bit per clock. A start pulse
// in IDLE or DONE captures a, b and cin. WIDTH cycles later the result is
// registered, and done pulses for one cycle. A start held high in DONE
// launches the next operation with no idle gap.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
//   defined   : ovf = signed (two's-complement) overflow of a + b + cin
//   undefined : ovf is tied to 0 and the carry-into-MSB flop is not built
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE or DONE
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle strobe when sum/cout/ovf update
//   sum    out  WIDTH-bit result, held until the next completion
//   cout   out  carry out of bit WIDTH-1
//   ovf    out  signed overflow (see macro above)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Half adder from four NANDs; returns {carry, sum}.
  function automatic logic [1:0] ha_nand(input logic x, input logic y);
    logic n1, n2, n3;
    n1 = ~(x & y);
    n2 = ~(x & n1);
    n3 = ~(y & n1);
    return {~n1, ~(n2 & n3)};
  endfunction

  // Full-adder slice working on the current LSBs and the carry flop.
  logic [1:0] ha1, ha2;
  logic       fa_s, fa_co;
  logic       last_bit;

  always_comb begin
    ha1   = ha_nand(a_sh_q[0], b_sh_q[0]);
    ha2   = ha_nand(ha1[0], carry_q);
    fa_s  = ha2[0];
    fa_co = ha1[1] | ha2[1];
  end

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at index 0.
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        // The counter may wrap on the final bit; it is reloaded on the next start.
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Both status bits decode straight from the state flop.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  // The carry out of bit WIDTH-2 is the carry into the MSB. It is captured
  // one cycle before completion, so ovf is a single XOR with the final carry.
  logic cmsb_q, cmsb_d;
  logic ovf_q, ovf_d;
  logic pre_last_bit;

  assign pre_last_bit = (cnt_q == CW'(WIDTH - 2));

  always_comb begin
    cmsb_d = cmsb_q;
    ovf_d  = ovf_q;
    if (state_q == RUN) begin
      if (pre_last_bit) cmsb_d = fa_co;
      if (last_bit)     ovf_d  = cmsb_q ^ fa_co;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cmsb_q <= cmsb_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomized + directed bench for serial_adder. The reference model tracks
// each accepted operation as a plain integer sum with a cycle countdown and
// checks every output on every falling edge outside reset.
module tb_serial_adder;

  localparam int W = 8;
`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif
  localparam longint MAXS = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int           rem    = 0;     // busy cycles left in the current operation
  bit           m_done = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  longint       p_tot  = 0;
  logic         p_ovf  = 1'b0;

  function automatic logic sovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    longint s;
    s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    return (s > MAXS) || (s < MINS);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= 0; m_done <= 1'b0; m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          m_done <= 1'b1;
          m_sum  <= p_tot[W-1:0];
          m_cout <= p_tot[W];
          m_ovf  <= p_ovf;
        end
      end else if (start) begin
        rem   <= W;
        p_tot <= longint'(a) + longint'(b) + longint'(cin);
        p_ovf <= OVF_ON & sovf(a, b, cin);
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (rst_n)
      chk("cycle {busy,done,cout,ovf,sum}",
          64'({busy, done, cout, ovf, sum}),
          64'({(rem > 0), m_done, m_cout, m_ovf, m_sum}));
  end

  // ---------------- stimulus helpers ----------------
  int e0;

  task automatic go(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    @(posedge clk); #1;
    start = 1'b1; a = xa; b = xb; cin = xc;
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_done(output int at_cyc);
    bit ok;
    ok = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin ok = 1'b1; at_cyc = cyc; end
    end
    if (!ok) chk("done timeout", 64'(0), 64'(1));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input logic [W-1:0] es, input logic ec, input logic eo);
    int t;
    go(xa, xb, xc);
    wait_done(t);
    chk({name, " latency"}, 64'(t - e0), 64'(W));
    chk({name, " sum"}, 64'(sum), 64'(es));
    chk({name, " cout"}, 64'(cout), 64'(ec));
    chk({name, " ovf"}, 64'(ovf), 64'(eo));
  endtask

  initial begin
    int d1, d2;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", 64'({busy, done, cout, ovf, sum}), 64'(0));
    rst_n = 1'b1;

    run_op("35+4A", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    chk("model pin 35+4A", 64'(m_sum), 64'(8'h7F));
    run_op("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    run_op("7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_ON);
    chk("model pin ovf", 64'(m_ovf), 64'(OVF_ON));
    run_op("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, OVF_ON);

    // start during RUN must be ignored
    go(8'h10, 8'h20, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d1);
    chk("ignore latency", 64'(d1 - e0), 64'(W));
    chk("ignore sum", 64'(sum), 64'(8'h30));

    // back-to-back with start held high
    @(posedge clk); #1;
    start = 1'b1; a = 8'h35; b = 8'h4A; cin = 1'b0;
    @(posedge clk); #1;
    a = 8'h01; b = 8'h01;
    wait_done(d1);
    chk("b2b first sum", 64'(sum), 64'(8'h7F));
    wait_done(d2);
    start = 1'b0;
    chk("b2b spacing", 64'(d2 - d1), 64'(W + 1));
    chk("b2b second sum", 64'(sum), 64'(8'h02));

    // asynchronous reset in the middle of RUN
    go(8'hC3, 8'h5A, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", 64'({busy, done, cout, ovf, sum}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("no done after reset", 64'(done), 64'(0));
    end
    run_op("post-reset 12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: a = 8'hFF;
        1: a = 8'h7F;
        2: a = 8'h80;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: b = 8'h00;
        1: b = 8'h80;
        2: b = 8'h01;
        default: b = W'($urandom);
      endcase
      cin = 1'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around one full-adder cell (two NAND half adders plus carry OR) and a carry flip-flop. It accepts two operands and a carry-in on a start pulse, adds one bit per clock LSB-first, and presents the registered sum and carry-out with a one-cycle done strobe. It sits directly downstream of the half-adder cell, trading WIDTH cycles of latency for a single adder slice.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range 2..32.

- clk    input   1       rising-edge clock
- rst_n  input   1       asynchronous active-low reset
- start  input   1       request; sampled only in IDLE or DONE
- a      input   WIDTH   operand A, captured on accepted start
- b      input   WIDTH   operand B, captured on accepted start
- cin    input   1       carry-in, captured on accepted start
- busy   output  1       high while bits are being processed
- done   output  1       one-cycle pulse when sum/cout/ovf become valid
- sum    output  WIDTH   result; holds last completed value
- cout   output  1       carry out of bit WIDTH-1
- ovf    output  1       signed overflow; see Configuration

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: start=1 → load a, b into shift registers, cin into carry FF, clear bit counter, go to RUN.
- RUN: each cycle, full-add a_sh[0], b_sh[0], carry; shift the sum bit into the MSB of the result shift register; shift a_sh and b_sh right by one; update carry; increment counter. After the cycle processing bit WIDTH-1, copy the result shift register to sum, carry to cout, and the overflow term to ovf, then go to DONE.
- DONE: done=1 for exactly this cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation, no idle gap); otherwise go to IDLE.
- start during RUN is ignored and has no effect on the operation in flight.
- a, b and cin are don't-care except on the accepting edge.
- sum, cout and ovf change only on the completion edge and hold across IDLE and the following RUN.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1).
- Bit counter width: $clog2(WIDTH) bits; no wrap is visible outside the block.

## Timing
- Reset: asynchronous assertion forces IDLE immediately and sets busy=0, done=0, sum=0, cout=0, ovf=0, and clears all shift registers and the carry FF. Reset mid-RUN discards the operation; no done is produced.
- Start accepted at edge E0 → busy=1 from E0 through edge E0+WIDTH (WIDTH cycles).
- Result registered and done=1 after edge E0+WIDTH; latency from accepting edge to valid result is WIDTH cycles.
- busy=0 and done=1 in the same cycle; done and busy are never both high.
- Back-to-back: start held high gives one result every WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined: a carry-into-MSB FF captures the carry entering bit WIDTH-1. At completion, ovf = carry_into_msb XOR cout (two's-complement overflow), registered and held like sum.
- Not defined: the ovf port remains present and is tied to 0. The carry-into-MSB FF is not built.

## Test plan
- WIDTH=8, a=0x35, b=0x4A, cin=0, start pulse → busy for 8 cycles, then done pulse with sum=0x7F, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Also a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1; a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1. Without the macro, the same cases give ovf=0.
- Start 0x10+0x20; pulse start with a=0xFF, b=0xFF at RUN cycle 3 → ignored, result 0x30, done exactly 8 cycles after the first start.
- Hold start high with a new operand pair presented in the DONE cycle (0x01+0x01 after 0x35+0x4A) → second operation begins with no idle gap; sum=0x7F then 0x02 on done pulses 9 cycles apart.
- Assert rst_n=0 at RUN cycle 4 → busy, done, sum, cout and ovf go to 0 without waiting for a clock edge; no done follows. A fresh start after reset release completes normally.
